button_bank: RTL

Parametrised multi-channel push-button conditioner: each of `N_BTN` raw button inputs is synchronised, debounced and turned into a clean level plus single-cycle press, release, long-press and auto-repeat events. It sits between the board button pins and the control FSMs, replacing per-button debounce/sync/edge-detect chains with one instance. All channels are independent and identical.

---
 rtl/button_pkg.sv | 19 +
 rtl/button_channel.sv | 134 +++++++++++++
 rtl/button_bank.sv | 43 ++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared types and width helpers for the push-button conditioner.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } hold_state_t;

    // Counter width for values up to v-1, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button lane: polarity fix, 2-flop sync, debounce, and press/hold event generation.
module button_channel
    import button_pkg::*;
#(
    parameter int DB_CYCLES     = 500000,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int REPEAT_EN     = 1,
    parameter bit INVERT        = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        x,
    output logic        level,
    output logic        press,
    output logic        release_evt,
    output logic        long_press,
    output logic        repeat_evt,
    output hold_state_t state
);

    localparam int DB_W   = clog2_min1(DB_CYCLES);
    localparam int HOLD_W = clog2_min1(max2(LONG_CYCLES, REPEAT_CYCLES));
    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_MAX = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_MAX  = HOLD_W'(REPEAT_CYCLES - 1);

    logic              s1;
    logic              s2;
    logic [DB_W-1:0]   db_cnt;
    logic              differ;
    logic              accept;
    logic              rise;
    logic              fall;

    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] cnt_nxt;
    hold_state_t       state_nxt;
    logic              long_nxt;
    logic              rpt_nxt;

    assign differ = (s2 != level);
    assign accept = differ && (db_cnt == DB_MAX);
    assign rise   = accept && s2;
    assign fall   = accept && !s2;

    // Any sample agreeing with the current level restarts the stability count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            db_cnt      <= '0;
            level       <= 1'b0;
            press       <= 1'b0;
            release_evt <= 1'b0;
        end else begin
            s1          <= x ^ INVERT;
            s2          <= s1;
            press       <= rise;
            release_evt <= fall;
            if (!differ) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_MAX) begin
                level  <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            long_press <= 1'b0;
            repeat_evt <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= cnt_nxt;
            long_press <= long_nxt;
            repeat_evt <= rpt_nxt;
        end
    end

    // The FSM follows the accept strobes so it moves in the same edge as press/release.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = hold_cnt;
        if (fall) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end
                end
                HELD: begin
                    if (hold_cnt == LONG_MAX) begin
                        state_nxt = LONG;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = hold_cnt + HOLD_W'(1);
                    end
                end
                LONG: begin
                    if ((REPEAT_EN != 0) && (hold_cnt == REP_MAX)) begin
                        cnt_nxt = '0;
                    end else if ((REPEAT_EN != 0) || (hold_cnt != '1)) begin
                        cnt_nxt = hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // A release landing on a threshold suppresses that threshold's pulse.
    always_comb begin
        long_nxt = 1'b0;
        rpt_nxt  = 1'b0;
        if (!fall) begin
            long_nxt = (state == HELD) && (hold_cnt == LONG_MAX);
            rpt_nxt  = (REPEAT_EN != 0) && (state == LONG) && (hold_cnt == REP_MAX);
        end
    end

endmodule

// File: rtl/button_bank.sv
// Bank of identical, independent button conditioners, one lane per pin.
module button_bank
    import button_pkg::*;
#(
    parameter int               N_BTN         = 4,
    parameter int               DB_CYCLES     = 500000,
    parameter int               LONG_CYCLES   = 50000000,
    parameter int               REPEAT_CYCLES = 10000000,
    parameter int               REPEAT_EN     = 1,
    parameter logic [N_BTN-1:0] ACTIVE_LOW    = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic        [N_BTN-1:0] x,
    output logic        [N_BTN-1:0] level,
    output logic        [N_BTN-1:0] press,
    output logic        [N_BTN-1:0] release_evt,
    output logic        [N_BTN-1:0] long_press,
    output logic        [N_BTN-1:0] repeat_evt,
    output hold_state_t [N_BTN-1:0] state
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .REPEAT_EN    (REPEAT_EN),
            .INVERT       (ACTIVE_LOW[i])
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .x          (x[i]),
            .level      (level[i]),
            .press      (press[i]),
            .release_evt(release_evt[i]),
            .long_press (long_press[i]),
            .repeat_evt (repeat_evt[i]),
            .state      (state[i])
        );
    end

endmodule
